// File: rtl/cory_p2s_n.sv
// -----------------------------------------------------------------------------
// cory_p2s_n -- parallel-to-serial width converter.
//
// Accepts one wide beat of R narrow slices (N bits each) and emits it as a
// sequence of narrow words, with zero bubble cycles between consecutive
// beats. Slice 0 (bits N-1:0) is emitted first unless MSB_FIRST=1, in which
// case slice R-1 is emitted first.
//
// Build options:
//   CORY_P2S_N_VARLEN_EN  defined   : i_a_n selects how many words to emit
//                                     (i_a_n+1, saturated to R).
//                         undefined : i_a_n is ignored; every beat emits R words.
//   SIM                   defined   : out-of-range R stops the simulation.
//
// Parameters:
//   N          narrow (output) word width in bits
//   R          input/output width ratio, 2..64
//   BS         width of slice index / count fields
//   MSB_FIRST  0: slice 0 first, 1: slice R-1 first
//
// Ports:
//   clk      clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   i_a_v    wide input valid
//   i_a_d    wide input data, N*R bits
//   i_a_n    number of narrow words to emit minus 1
//   o_a_r    wide input ready
//   o_z_v    narrow output valid
//   o_z_d    narrow output data
//   o_z_s    slice index of o_z_d within its source beat
//   o_z_l    last narrow word of the source beat
//   i_z_r    narrow output ready
// -----------------------------------------------------------------------------
module cory_p2s_n #(
  parameter int N         = 8,
  parameter int R         = 4,
  parameter int BS        = $clog2(R),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_a_v,
  input  logic [N*R-1:0] i_a_d,
  input  logic [BS-1:0]  i_a_n,
  output logic           o_a_r,
  output logic           o_z_v,
  output logic [N-1:0]   o_z_d,
  output logic [BS-1:0]  o_z_s,
  output logic           o_z_l,
  input  logic           i_z_r
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [BS-1:0] LAST_SLICE = BS'(R - 1);

`ifdef SIM
  initial begin
    if (R < 2 || R > 64) begin
      $display("ERROR: cory_p2s_n parameter R=%0d is outside 2..64", R);
      $finish;
    end
  end
`endif

  state_t         state;
  logic [N*R-1:0] hold;
  logic [BS-1:0]  cnt;
  logic [BS-1:0]  lim;
  logic [BS-1:0]  lim_load;
  logic [BS-1:0]  slice_idx;
  logic [N-1:0]   slice_data;
  logic           accept;
  logic           xfer;

  // Limit to load on accept; requests longer than one beat are clipped.
`ifdef CORY_P2S_N_VARLEN_EN
  assign lim_load = (int'(i_a_n) > R - 1) ? LAST_SLICE : i_a_n;
`else
  logic unused_i_a_n;
  assign unused_i_a_n = ^i_a_n;
  assign lim_load     = LAST_SLICE;
`endif

  // Emission order: counter walks up from 0, index mirrors it for MSB-first.
  assign slice_idx = MSB_FIRST ? (LAST_SLICE - cnt) : cnt;

  // NOTE: every variable written in always_comb gets a default first,
  // otherwise an unmatched path would infer a latch.
  always_comb begin
    slice_data = '0;
    for (int i = 0; i < R; i++) begin
      if (slice_idx == BS'(i)) slice_data = hold[i*N +: N];
    end
  end

  assign o_z_v = (state == SEND);
  assign o_z_l = o_z_v && (cnt == lim);
  // Gate data/index so the idle bus reads all-zero regardless of MSB_FIRST.
  assign o_z_s = o_z_v ? slice_idx  : '0;
  assign o_z_d = o_z_v ? slice_data : '0;

  // Ready in SEND only when the last word leaves this cycle, so the next
  // beat loads in the same edge and no bubble appears.
  assign o_a_r  = (state == IDLE) || (o_z_l && i_z_r);
  assign accept = i_a_v && o_a_r;
  assign xfer   = o_z_v && i_z_r;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  // NOTE: the hold register is cleared by reset as well, which keeps the
  // data path deterministic right after reset; it is a plain flop bank, not
  // an inferred RAM, so the reset costs no memory macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      hold  <= '0;
      cnt   <= '0;
      lim   <= '0;
    end else if (accept) begin
      state <= SEND;
      hold  <= i_a_d;
      lim   <= lim_load;
      cnt   <= '0;
    end else if (xfer) begin
      if (cnt == lim) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
